// File: rtl/wave_display.sv
// wave_display: read side of the ping-pong waveform buffer. Fetches the
// sample for each pixel column and draws the trace as vertical segments.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   x, y, valid        pixel coordinate and visible flag (stage 0)
//   read_index         half the capture block is writing
//   read_value         RAM data for the registered read_address
//   read_address       RAM read address {~disp_index, column}
//   valid_pixel        r/g/b belong to a visible pixel
//   r, g, b            pixel colour (COLOR on the trace, else 0)
//   wave_display_idle  beam is below the wave rows; safe to swap
module wave_display #(
  parameter logic [7:0] COLOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);

  // Buffer half frozen for the whole wave region of a frame.
  logic       disp_index;

  // Stage-1 sideband, aligned with read_value.
  logic [7:0] col1;
  logic       x1_lsb;
  logic [7:0] ys1;
  logic       valid1;
  logic       inregion1;

  // Target row of the last pixel of the previous column.
  logic [7:0] prev_t;

  logic       in_region;
  logic [7:0] t;
  logic [7:0] p;
  logic [7:0] lo;
  logic [7:0] hi;
  logic       draw;

  // Rows are drawn at half vertical resolution; y[0] never matters.
  logic       unused_y0;
  assign unused_y0 = y[0];

  assign in_region = (x[10:9] == 2'b01) && !y[9];

  always_ff @(posedge clk) begin
    if (reset) begin
      read_address      <= '0;
      wave_display_idle <= 1'b0;
      disp_index        <= 1'b0;
      col1              <= '0;
      x1_lsb            <= 1'b0;
      ys1               <= '0;
      valid1            <= 1'b0;
      inregion1         <= 1'b0;
    end else begin
      read_address      <= {~disp_index, x[8:1]};
      wave_display_idle <= y[9];
      // Only swap halves while the beam is outside the wave rows,
      // so a single frame never mixes two captures.
      if (wave_display_idle)
        disp_index <= read_index;
      col1              <= x[8:1];
      x1_lsb            <= x[0];
      ys1               <= y[8:1];
      valid1            <= valid;
      inregion1         <= in_region;
    end
  end

  // Larger samples sit higher on screen.
  assign t = 8'd255 - read_value;

  // First column of a line has no predecessor: draw a single point.
  assign p = (col1 == 8'd0) ? t : prev_t;

  always_comb begin
    lo = t;
    hi = p;
    if (p < t) begin
      lo = p;
      hi = t;
    end
  end

  assign draw = valid1 && inregion1
             && (ys1 >= lo) && (ys1 <= hi);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_t      <= '0;
      valid_pixel <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      // Second pixel of each 2-pixel column hands its row to the next.
      if (x1_lsb)
        prev_t <= t;
      valid_pixel <= valid1;
      r           <= draw ? COLOR : 8'd0;
      g           <= draw ? COLOR : 8'd0;
      b           <= draw ? COLOR : 8'd0;
    end
  end

endmodule

// File: tb/tb_wave_display.sv
// tb_wave_display: table vectors, directed sequences and a random raster
// run checked against a pixel-level reference model.
module tb_wave_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        valid = 1'b0;
  logic        read_index = 1'b0;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        wave_display_idle;

  logic [7:0]  mem [0:511];

  // RAM: read_address is the registered address of the RAM.
  assign read_value = mem[read_address];

  always #5 clk = ~clk;

  wave_display #(.COLOR(8'hFF)) dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .y(y),
    .valid(valid),
    .read_index(read_index),
    .read_value(read_value),
    .read_address(read_address),
    .valid_pixel(valid_pixel),
    .r(r),
    .g(g),
    .b(b),
    .wave_display_idle(wave_display_idle)
  );

  typedef struct packed {
    logic       vp;
    logic [7:0] col;
  } exp_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        v;
    logic        evp;
    logic [7:0]  ecol;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  exp_t       q[$];
  logic       disp_m = 1'b0;
  logic       idle_m = 1'b0;
  logic [7:0] prev_m = '0;
  logic [8:0] exp_addr = '0;
  logic       ri_g = 1'b0;

  // Outputs sampled at the start of the latest step
  logic       act_vp;
  logic [7:0] act_r;
  logic [7:0] act_g;
  logic [7:0] act_b;
  logic [8:0] act_addr;
  logic       act_idle;

  vec_t tbl [0:14];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input logic [10:0] sx, input logic [9:0] sy,
                      input logic sv, input logic sri,
                      input logic srst);
    exp_t       e;
    logic [7:0] smp;
    logic [7:0] t;
    logic [7:0] p;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] ys;
    logic       drw;
    @(negedge clk);
    act_vp   = valid_pixel;
    act_r    = r;
    act_g    = g;
    act_b    = b;
    act_addr = read_address;
    act_idle = wave_display_idle;
    e = q.pop_front();
    check("valid_pixel", act_vp, e.vp);
    check("r", act_r, e.col);
    check("g", act_g, e.col);
    check("b", act_b, e.col);
    check("read_address", act_addr, exp_addr);
    check("idle", act_idle, idle_m);
    x = sx;
    y = sy;
    valid = sv;
    read_index = sri;
    reset = srst;
    if (srst) begin
      q[q.size()-1] = '0;
      q.push_back('0);
      prev_m   = '0;
      disp_m   = 1'b0;
      idle_m   = 1'b0;
      exp_addr = '0;
    end else begin
      smp = mem[{~disp_m, sx[8:1]}];
      t   = 8'd255 - smp;
      p   = (sx[8:1] == 8'd0) ? t : prev_m;
      lo  = (p < t) ? p : t;
      hi  = (p < t) ? t : p;
      ys  = sy[8:1];
      drw = sv && (sx >= 11'd512) && (sx <= 11'd1023)
         && (sy <= 10'd511) && (ys >= lo) && (ys <= hi);
      e.vp  = sv;
      e.col = drw ? 8'hFF : 8'h00;
      q.push_back(e);
      if (sx[0]) prev_m = t;
      exp_addr = {~disp_m, sx[8:1]};
      if (idle_m) disp_m = sri;
      idle_m = sy[9];
    end
  endtask

  // Two blank cycles so no pending read sees a RAM update.
  task automatic flush();
    repeat (2) step(11'd0, 10'd0, 1'b0, ri_g, 1'b0);
  endtask

  // Latch read_index=1 during idle rows: display reads half 0.
  task automatic select_half0();
    ri_g = 1'b1;
    repeat (2) step(11'd0, 10'd512, 1'b0, 1'b1, 1'b0);
    flush();
  endtask

  int         lit;
  int         bad;
  logic [10:0] rx;
  logic [9:0]  ry;

  initial begin
    q.push_back('0);
    q.push_back('0);
    for (int i = 0; i < 512; i++) mem[i] = 8'd128;

    // Power-on reset, then reset held 3 cycles mid-frame.
    repeat (2) step(11'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    step(11'd598, 10'd254, 1'b1, 1'b0, 1'b0);
    step(11'd599, 10'd254, 1'b1, 1'b0, 1'b0);
    repeat (3) step(11'd600, 10'd100, 1'b1, 1'b0, 1'b1);
    step(11'd600, 10'd254, 1'b1, 1'b0, 1'b0);
    check("rst_colour", act_r, 8'h00);
    check("rst_vp", act_vp, 1'b0);
    check("rst_addr", act_addr, 9'd0);
    step(11'd600, 10'd254, 1'b1, 1'b0, 1'b0);
    check("rel1_colour", act_r, 8'h00);
    step(11'd600, 10'd254, 1'b1, 1'b0, 1'b0);
    check("rel2_colour", act_r, 8'hFF);
    check("rel2_vp", act_vp, 1'b1);

    // Half 0 flat at 128, half 1 zeros.
    flush();
    for (int i = 256; i < 512; i++) mem[i] = 8'd0;
    select_half0();

    lit = 0;
    bad = 0;
    for (int i = 0; i < 514; i++) begin
      if (i < 512) step(11'(512 + i), 10'd254, 1'b1, 1'b1, 1'b0);
      else step(11'd0, 10'd0, 1'b0, 1'b1, 1'b0);
      if (i >= 2 && act_r == 8'hFF && act_g == 8'hFF && act_b == 8'hFF)
        lit++;
      if (i >= 1 && act_addr[8]) bad++;
    end
    check("sweep254_lit", lit, 512);
    check("sweep254_addr8", bad, 0);

    lit = 0;
    for (int i = 0; i < 514; i++) begin
      if (i < 512) step(11'(512 + i), 10'd200, 1'b1, 1'b1, 1'b0);
      else step(11'd0, 10'd0, 1'b0, 1'b1, 1'b0);
      if (i >= 2 && (act_r | act_g | act_b) != 8'h00) lit++;
    end
    check("sweep200_lit", lit, 0);

    // read_index toggles mid-frame: no effect until idle.
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step(11'(512 + i), 10'd300, 1'b1, 1'b0, 1'b0);
      if (act_addr[8]) bad++;
    end
    check("swap_frozen", bad, 0);
    step(11'd0, 10'd512, 1'b0, 1'b0, 1'b0);
    step(11'd0, 10'd512, 1'b0, 1'b0, 1'b0);
    check("idle_rise", act_idle, 1'b1);
    step(11'd512, 10'd0, 1'b1, 1'b0, 1'b0);
    step(11'd514, 10'd0, 1'b1, 1'b0, 1'b0);
    check("swap_addr8", act_addr[8], 1'b1);
    ri_g = 1'b0;

    // Step waveform in half 0.
    flush();
    for (int i = 0; i < 256; i++) mem[i] = 8'd128;
    mem[10] = 8'd192;
    for (int i = 256; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    select_half0();

    tbl[0]  = '{11'd513, 10'd254, 1'b1, 1'b1, 8'hFF};
    tbl[1]  = '{11'd531, 10'd254, 1'b1, 1'b1, 8'hFF};
    tbl[2]  = '{11'd532, 10'd126, 1'b1, 1'b1, 8'hFF};
    tbl[3]  = '{11'd532, 10'd124, 1'b1, 1'b1, 8'h00};
    tbl[4]  = '{11'd532, 10'd256, 1'b1, 1'b1, 8'h00};
    tbl[5]  = '{11'd532, 10'd254, 1'b1, 1'b1, 8'hFF};
    tbl[6]  = '{11'd533, 10'd200, 1'b1, 1'b1, 8'hFF};
    tbl[7]  = '{11'd534, 10'd254, 1'b1, 1'b1, 8'hFF};
    tbl[8]  = '{11'd535, 10'd100, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{11'd533, 10'd254, 1'b1, 1'b1, 8'hFF};
    tbl[10] = '{11'd512, 10'd126, 1'b1, 1'b1, 8'h00};
    tbl[11] = '{11'd513, 10'd254, 1'b1, 1'b1, 8'hFF};
    tbl[12] = '{11'd100, 10'd254, 1'b1, 1'b1, 8'h00};
    tbl[13] = '{11'd600, 10'd700, 1'b1, 1'b1, 8'h00};
    tbl[14] = '{11'd532, 10'd254, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].x, tbl[i].y, tbl[i].v, ri_g, 1'b0);
      step(11'd0, 10'd0, 1'b0, ri_g, 1'b0);
      if (i == 13) check("tbl_idle_y700", wave_display_idle, 1'b1);
      step(11'd0, 10'd0, 1'b0, ri_g, 1'b0);
      check($sformatf("tbl%0d_vp", i), act_vp, tbl[i].evp);
      check($sformatf("tbl%0d_col", i), act_r, tbl[i].ecol);
    end

    // Random raster against the model.
    flush();
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    rx = 11'd512;
    ry = 10'd0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 31) == 0)
        rx = 11'($urandom_range(0, 1023));
      else
        rx = (rx + 11'd1) & 11'h3FF;
      if (rx == 11'd0 || $urandom_range(0, 63) == 0)
        ry = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) ri_g = ~ri_g;
      step(rx, ry, ($urandom_range(0, 3) != 0), ri_g,
           ($urandom_range(0, 299) == 0));
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
